// File: rtl/conv_pe_sequencer.sv
// conv_pe_sequencer: walks one fp16 MAC PE through a KxK conv window,
// fetching operand pairs from two sync-read buffers and handing back the sum.
module conv_pe_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] img_base,
  input  logic [ADDR_WIDTH-1:0] img_stride,
  input  logic [ADDR_WIDTH-1:0] wgt_base,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] img_addr,
  output logic [ADDR_WIDTH-1:0] wgt_addr,
  input  logic [DATA_WIDTH-1:0] img_rdata,
  input  logic [DATA_WIDTH-1:0] wgt_rdata,
  output logic                  pe_clear,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  input  logic [DATA_WIDTH-1:0] pe_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);
  localparam int CW = KERNEL_SIZE > 1 ? $clog2(KERNEL_SIZE) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, OUT} state_t;
  state_t                r_state, w_next;
  logic [CW-1:0]         r_row, r_col;
  logic [ADDR_WIDTH-1:0] r_img_base, r_img_stride, r_wgt_base, r_img_row, r_wgt_row;
  logic                  r_opv, r_pe_clear;
  logic                  w_accept, w_issue, w_col_end, w_last;
  assign w_accept  = r_state == IDLE && start;
  assign w_issue   = r_state == CLEAR || r_state == RUN;
  assign w_col_end = r_col == CW'(KERNEL_SIZE - 1);
  assign w_last    = w_col_end && r_row == CW'(KERNEL_SIZE - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = start ? CLEAR : IDLE;
      CLEAR, RUN: w_next = w_last ? DRAIN : RUN;
      DRAIN:      w_next = OUT;
      OUT:        w_next = out_ready ? IDLE : OUT;
      default:    w_next = IDLE;
    endcase
  end
  // row offsets are accumulated so no multiplier sits in the address path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_opv        <= 1'b0;
      r_pe_clear   <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_img_base   <= '0;
      r_img_stride <= '0;
      r_wgt_base   <= '0;
      r_img_row    <= '0;
      r_wgt_row    <= '0;
    end else begin
      r_state    <= w_next;
      r_opv      <= w_issue;
      r_pe_clear <= w_accept;
      if (w_accept) begin
        r_img_base   <= img_base;
        r_img_stride <= img_stride;
        r_wgt_base   <= wgt_base;
        r_row        <= '0;
        r_col        <= '0;
        r_img_row    <= '0;
        r_wgt_row    <= '0;
      end else if (w_issue) begin
        r_col <= w_col_end ? '0 : r_col + 1'b1;
        if (w_col_end) begin
          r_row     <= r_row + 1'b1;
          r_img_row <= r_img_row + r_img_stride;
          r_wgt_row <= r_wgt_row + ADDR_WIDTH'(KERNEL_SIZE);
        end
      end
    end
  end
  assign busy      = r_state != IDLE;
  assign rd_en     = w_issue;
  assign img_addr  = w_issue ? r_img_base + r_img_row + ADDR_WIDTH'(r_col) : '0;
  assign wgt_addr  = w_issue ? r_wgt_base + r_wgt_row + ADDR_WIDTH'(r_col) : '0;
  assign pe_clear  = r_pe_clear;
  assign pe_a      = r_opv ? img_rdata : '0;
  assign pe_b      = r_opv ? wgt_rdata : '0;
  assign out_valid = r_state == OUT;
  assign out_data  = out_valid ? pe_result : '0;
endmodule

// File: tb/tb_conv_pe_sequencer.sv
// tb_conv_pe_sequencer: drives conv_pe_sequencer with buffer and fp16 PE models
// and checks window sums, address streams and handshake timing.
module tb_conv_pe_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [9:0]  img_base, img_stride, wgt_base, img_addr, wgt_addr;
  logic        busy, rd_en, pe_clear, out_valid;
  logic [15:0] img_rdata, wgt_rdata, pe_a, pe_b, out_data;
  logic [15:0] pe_result = 16'h0;
  logic [15:0] img_mem [1024];
  logic [15:0] wgt_mem [1024];
  logic [9:0]  ia_q[$], wa_q[$];
  int          rise_q[$];
  int          n_clr = 0;
  int          total = 0, bad = 0;
  real         acc = 0.0;

  conv_pe_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .img_base(img_base), .img_stride(img_stride),
    .wgt_base(wgt_base), .busy(busy), .rd_en(rd_en), .img_addr(img_addr), .wgt_addr(wgt_addr),
    .img_rdata(img_rdata), .wgt_rdata(wgt_rdata), .pe_clear(pe_clear), .pe_a(pe_a), .pe_b(pe_b),
    .pe_result(pe_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    m = (h[14:10] == 5'd0) ? h[9:0] / 1024.0 : 1.0 + h[9:0] / 1024.0;
    e = (h[14:10] == 5'd0) ? -14 : int'(h[14:10]) - 15;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    real  m;
    int   e, f;
    logic s;
    if (v == 0.0) return 16'h0000;
    s = v < 0.0;
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    f = int'((m - 1.0) * 1024.0);
    if (f == 1024) begin f = 0; e++; end
    return {s, 5'(e + 15), 10'(f)};
  endfunction

  // window sum straight from the tap address formulas
  function automatic logic [15:0] ref_sum(input logic [9:0] ib, input logic [9:0] st, input logic [9:0] wb);
    real        s;
    logic [9:0] ia, wa;
    s = 0.0;
    for (int t = 0; t < 9; t++) begin
      ia = ib + 10'(t / 3) * st + 10'(t % 3);
      wa = wb + 10'(t);
      s = s + h2r(img_mem[ia]) * h2r(wgt_mem[wa]);
    end
    return r2h(s);
  endfunction

  // sync-read buffers; idle cycles return 2.0 so ungated operands corrupt the sum
  always @(posedge clk) begin
    img_rdata <= rd_en ? img_mem[img_addr] : 16'h4000;
    wgt_rdata <= rd_en ? wgt_mem[wgt_addr] : 16'h4000;
  end

  always @(posedge clk or posedge pe_clear) begin
    if (pe_clear) begin
      acc       <= 0.0;
      pe_result <= 16'h0000;
    end else if (!$isunknown({pe_a, pe_b})) begin
      acc       <= acc + h2r(pe_a) * h2r(pe_b);
      pe_result <= r2h(acc + h2r(pe_a) * h2r(pe_b));
    end
  end

  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      ia_q.push_back(img_addr);
      wa_q.push_back(wgt_addr);
    end
    if (pe_clear === 1'b1) n_clr <= n_clr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"}, {28'd0, busy, rd_en, pe_clear, out_valid}, 32'd0);
    chk({tag, "_addr"}, {12'd0, img_addr, wgt_addr}, 32'd0);
    chk({tag, "_data"}, {pe_a, pe_b}, 32'd0);
    chk({tag, "_out"}, {16'd0, out_data}, 32'd0);
  endtask

  task automatic run_win(input logic [9:0] ib, input logic [9:0] st, input logic [9:0] wb,
                         input int stall, input int poke, input logic [15:0] exp_res);
    int          q0, c0, lat;
    logic [15:0] res;
    logic [9:0]  ea, ew;
    @(negedge clk);
    q0 = ia_q.size();
    c0 = n_clr;
    start = 1'b1; img_base = ib; img_stride = st; wgt_base = wb;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = (lat == poke);
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'd11);
    chk("rd_count", 32'(ia_q.size() - q0), 32'd9);
    chk("clear_pulses", 32'(n_clr - c0), 32'd1);
    for (int t = 0; t < 9; t++) begin
      ea = ib + 10'(t / 3) * st + 10'(t % 3);
      ew = wb + 10'(t);
      chk($sformatf("addr_tap%0d", t), {12'd0, ia_q[q0 + t], wa_q[q0 + t]}, {12'd0, ea, ew});
    end
    res = out_data;
    chk("result", {16'd0, res}, {16'd0, exp_res});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_hold", {12'd0, busy, out_valid, rd_en, pe_clear, out_data}, {12'd0, 4'b1100, res});
      chk("stall_ops", {pe_a, pe_b}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_handshake", {30'd0, busy, out_valid}, 32'd0);
  endtask

  initial begin
    int          q0, prev, k;
    logic [9:0]  ib, st, wb;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    img_base = '0; img_stride = '0; wgt_base = '0;
    for (int i = 0; i < 1024; i++) begin img_mem[i] = 16'h3C00; wgt_mem[i] = 16'h3800; end
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;
    // 1.0 * 0.5 over nine taps, with a five-cycle consumer stall
    run_win(10'd0, 10'd8, 10'd100, 5, 0, 16'h4480);
    // zero weights after a 4.5 window proves the PE was re-cleared
    for (int i = 0; i < 1024; i++) wgt_mem[i] = 16'h0000;
    run_win(10'd0, 10'd8, 10'd100, 0, 0, 16'h0000);
    for (int i = 0; i < 1024; i++) begin
      k = int'($urandom_range(0, 10)) - 3;
      img_mem[i] = r2h(real'(k) * 0.5);
      k = int'($urandom_range(0, 8)) - 4;
      wgt_mem[i] = r2h(real'(k) * 0.25);
    end
    for (int n = 0; n < 6; n++) begin
      ib = 10'($urandom);
      st = 10'($urandom_range(0, 63));
      wb = 10'($urandom);
      run_win(ib, st, wb, int'($urandom_range(0, 3)), 0, ref_sum(ib, st, wb));
    end
    // start pulse mid-RUN must be dropped
    run_win(10'd200, 10'd16, 10'd40, 0, 4, ref_sum(10'd200, 10'd16, 10'd40));
    repeat (3) @(negedge clk);
    chk("no_queued_start", {31'd0, busy}, 32'd0);
    // abort during tap 4, then a clean window
    @(negedge clk);
    start = 1'b1; img_base = 10'd37; img_stride = 10'd20; wgt_base = 10'd500;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    @(negedge clk);
    chk_idle_outputs("mid_reset_next");
    reset = 1'b0;
    run_win(10'd37, 10'd20, 10'd500, 1, 0, ref_sum(10'd37, 10'd20, 10'd500));
    // address wrap at the top of the buffer
    q0 = ia_q.size();
    run_win(10'h3FE, 10'd1, 10'h3FC, 0, 0, ref_sum(10'h3FE, 10'd1, 10'h3FC));
    chk("wrap_tap2", {22'd0, ia_q[q0 + 2]}, 32'h000);
    chk("wrap_tap5", {22'd0, ia_q[q0 + 5]}, 32'h001);
    // back-to-back with start and out_ready held high
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; img_base = 10'd5; img_stride = 10'd9; wgt_base = 10'd77;
    prev = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1 && prev == 0) rise_q.push_back(i);
      prev = (out_valid === 1'b1) ? 1 : 0;
    end
    start = 1'b0;
    chk("b2b_first", 32'(rise_q.size() > 0 ? rise_q[0] : 0), 32'd11);
    chk("b2b_period", 32'(rise_q.size() > 1 ? rise_q[1] - rise_q[0] : 0), 32'd12);
    repeat (20) @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
